layer1_window_gen: RTL and testbench

//  Consumer end of the layer-1 pixel delay chain. Accepts a raster-order pixel stream, keeps the last
//  two image rows in internal line buffers and emits one 3x3 convolution window per pixel whose window

---
 rtl/layer1_window_gen.sv | 113 +++++++++++
 tb/tb_layer1_window_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/layer1_window_gen.sv
// ---------------------------------------------------------------------------
// layer1_window_gen
//   Consumer end of the layer-1 pixel delay chain. Takes a raster-order pixel
//   stream, keeps the previous two image rows in line buffers and produces one
//   3x3 window for every pixel whose window lies entirely inside the image.
//   The window goes to the layer-1 MAC array over a valid/ready handshake.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   in_valid     in_pixel valid
//   in_ready     block can take in_pixel this cycle
//   in_pixel     pixel, raster order
//   out_valid    out_window valid
//   out_ready    downstream takes out_window this cycle
//   out_window   3x3 window, slot k=3*row+col at [k*DATA_W +: DATA_W], slot0 top-left
//   out_row      image row of window top-left
//   out_col      image col of window top-left
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module layer1_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*DATA_W-1:0]       out_window,
    output logic [$clog2(IMG_H)-1:0]  out_row,
    output logic [$clog2(IMG_W)-1:0]  out_col,
    output logic                      frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    // lb1_q holds row r-2, lb0_q holds row r-1 at the column being written
    logic [IMG_W-1:0][DATA_W-1:0] lb0_q, lb1_q;
    // Window register doubles as the output register; slot 3*wr+wc
    logic [8:0][DATA_W-1:0]       win_q, win_d;
    logic [RW-1:0]                row_q, row_d, out_row_q;
    logic [CW-1:0]                col_q, col_d, out_col_q;
    logic                         out_valid_q, frame_done_q;
    logic                         accept, last_col, last_row;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_col   = (col_q == CW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - 1));

    assign out_valid  = out_valid_q;
    assign out_window = win_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

    // Shift columns left, new right column comes from the line buffers plus
    // the incoming pixel. Left columns carry stale data right after a row
    // wrap, but those windows (c<2) are never flagged valid.
    always_comb begin
        win_d = win_q;
        for (int wr = 0; wr < 3; wr++) begin
            win_d[3*wr+0] = win_q[3*wr+1];
            win_d[3*wr+1] = win_q[3*wr+2];
        end
        win_d[2] = lb1_q[col_q];
        win_d[5] = lb0_q[col_q];
        win_d[8] = in_pixel;
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q + CW'(1);
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lb0_q        <= '0;
            lb1_q        <= '0;
            win_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (accept) begin
            win_q          <= win_d;
            lb0_q[col_q]   <= in_pixel;
            lb1_q[col_q]   <= lb0_q[col_q];
            row_q          <= row_d;
            col_q          <= col_d;
            // Row/col are only meaningful when the window is valid
            out_valid_q    <= (row_q >= RW'(2)) && (col_q >= CW'(2));
            out_row_q      <= row_q - RW'(2);
            out_col_q      <= col_q - CW'(2);
            frame_done_q   <= last_row && last_col;
        end else begin
            frame_done_q <= 1'b0;
            // Drop valid only once the pending window has been taken
            if (out_ready) out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer1_window_gen.sv
module tb_layer1_window_gen;
    localparam int DW = 16;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int WB = 9*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_pixel = '0;
    logic          in_ready, out_valid, frame_done;
    logic [WB-1:0] out_window;
    logic [4:0]    out_row, out_col;

    layer1_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_window(out_window), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the whole current frame as a 2D image and builds each expected
    // window directly from image coordinates.
    logic [DW-1:0] img [H][W];
    int            mr, mc, facc;
    bit            armed = 0;
    bit            exp_vld, fd_pend;
    logic [WB-1:0] exp_win;
    int            exp_row, exp_col;

    // statistics, cleared by the stimulus between tests
    int            win_cnt, fd_cnt, first_acc, max_row, max_col;
    bit            first_seen;
    logic [WB-1:0] first_win, last_win;
    int            first_row, first_col, last_row, last_col;

    task automatic clear_stats();
        win_cnt = 0; fd_cnt = 0; first_seen = 0; first_acc = -1;
        max_row = 0; max_col = 0; first_win = '0; last_win = '0;
        first_row = -1; first_col = -1; last_row = -1; last_col = -1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", WB'(in_ready), WB'(!exp_vld || out_ready));
            chk("out_valid", WB'(out_valid), WB'(exp_vld));
            chk("frame_done", WB'(frame_done), WB'(fd_pend));
            if (frame_done) fd_cnt++;
            if (out_valid && exp_vld) begin
                chk("out_window", out_window, exp_win);
                chk("out_row", WB'(out_row), WB'(exp_row));
                chk("out_col", WB'(out_col), WB'(exp_col));
                if (out_ready) begin
                    win_cnt++;
                    if (!first_seen) begin
                        first_seen = 1; first_acc = facc;
                        first_win = out_window; first_row = out_row; first_col = out_col;
                    end
                    last_win = out_window; last_row = out_row; last_col = out_col;
                    if (int'(out_row) > max_row) max_row = out_row;
                    if (int'(out_col) > max_col) max_col = out_col;
                end
            end
        end
        if (rst) begin
            armed = 1; exp_vld = 0; fd_pend = 0; mr = 0; mc = 0; facc = 0;
            exp_win = '0; exp_row = 0; exp_col = 0;
        end else if (armed) begin
            fd_pend = 0;
            if (in_valid && in_ready) begin
                img[mr][mc] = in_pixel;
                facc++;
                if (mr >= 2 && mc >= 2) begin
                    exp_vld = 1;
                    for (int wr = 0; wr < 3; wr++)
                        for (int wc = 0; wc < 3; wc++)
                            exp_win[(3*wr+wc)*DW +: DW] = img[mr-2+wr][mc-2+wc];
                    exp_row = mr - 2; exp_col = mc - 2;
                end else begin
                    exp_vld = 0;
                end
                if (mr == H-1 && mc == W-1) fd_pend = 1;
                mc++;
                if (mc == W) begin
                    mc = 0; mr++;
                    if (mr == H) begin mr = 0; facc = 0; end
                end
            end else if (out_ready) begin
                exp_vld = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [DW-1:0] p, input bit stall);
        int n;
        in_valid = 1; in_pixel = p; n = 0;
        if (stall) begin
            out_ready = 0;
            fork
                begin repeat (5) @(posedge clk); #1 out_ready = 1; end
            join_none
        end
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                errors++; checks++;
                $display("FAIL accept_timeout actual=stalled expected=accept pixel=%0d", p);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic frame(input bit gaps, input int stall_at, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(1) == 1) idle(1);
            push(DW'(i), i == stall_at);
        end
    endtask

    logic [WB-1:0] lit_first;
    logic [WB-1:0] tmp;

    initial begin
        lit_first = {16'd66, 16'd65, 16'd64, 16'd34, 16'd33, 16'd32, 16'd2, 16'd1, 16'd0};
        clear_stats();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", WB'(out_valid), '0);
        chk("rst_frame_done", WB'(frame_done), '0);
        chk("rst_out_window", out_window, '0);
        chk("rst_out_row", WB'(out_row), '0);
        chk("rst_out_col", WB'(out_col), '0);
        @(posedge clk); #1;

        // Gap-free frame with a 5-cycle downstream stall
        clear_stats();
        frame(0, 100, W*H);
        idle(4);
        chk("f1_windows", WB'(win_cnt), WB'(900));
        chk("f1_frame_done", WB'(fd_cnt), WB'(1));
        chk("f1_first_acc", WB'(first_acc), WB'(67));
        chk("f1_first_win", first_win, lit_first);
        chk("f1_first_row", WB'(first_row), WB'(0));
        chk("f1_first_col", WB'(first_col), WB'(0));
        tmp = last_win >> (8*DW);
        chk("f1_last_slot8", tmp, WB'(1023));
        chk("f1_last_row", WB'(last_row), WB'(29));
        chk("f1_last_col", WB'(last_col), WB'(29));

        // Random input gaps
        clear_stats();
        frame(1, -1, W*H);
        idle(4);
        chk("f2_windows", WB'(win_cnt), WB'(900));
        chk("f2_frame_done", WB'(fd_cnt), WB'(1));
        chk("f2_first_win", first_win, lit_first);

        // Reset mid-frame, then fresh ramp
        frame(0, -1, 400);
        rst = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", WB'(out_valid), '0);
        chk("mid_rst_out_window", out_window, '0);
        @(posedge clk); #1;
        clear_stats();
        frame(0, -1, W*H);
        idle(4);
        chk("f3_first_acc", WB'(first_acc), WB'(67));
        chk("f3_first_slot0", WB'(first_win[DW-1:0]), '0);
        chk("f3_windows", WB'(win_cnt), WB'(900));

        // Two frames back to back
        clear_stats();
        frame(0, -1, W*H);
        frame(0, -1, W*H);
        idle(4);
        chk("f45_windows", WB'(win_cnt), WB'(1800));
        chk("f45_frame_done", WB'(fd_cnt), WB'(2));
        chk("f45_max_row", WB'(max_row), WB'(29));
        chk("f45_max_col", WB'(max_col), WB'(29));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
